// File: rtl/genius_pkg.sv
// Types shared by the game controller and its input conditioner: the colour
// encoding, the conditioner FSM state type and a one-hot to colour encoder.
package genius_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        RED    = 2'b01,
        BLUE   = 2'b10,
        YELLOW = 2'b11
    } color_e;

    localparam int unsigned NumColors = 4;

    // Kept as a plain vector type so state constants stay legacy-compatible.
    typedef logic [0:0] cond_state_e;

    localparam cond_state_e StIdle = 1'b0;
    localparam cond_state_e StHeld = 1'b1;

    // Bit index of the set bit equals the colour code; non-one-hot inputs map to GREEN.
    function automatic color_e onehot_to_color(input logic [NumColors-1:0] onehot);
        color_e color;
        color = GREEN;
        case (onehot)
            4'b0001: color = GREEN;
            4'b0010: color = RED;
            4'b0100: color = BLUE;
            4'b1000: color = YELLOW;
            default: color = GREEN;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/color_input_conditioner_if.sv
// Bundle of raw button inputs and conditioned press outputs between the panel
// (master) and the input conditioner (slave).
interface color_input_conditioner_if #(
    parameter int unsigned COLOR_CODEFY_W = 2
) ();

    logic                      button_color_green;
    logic                      button_color_red;
    logic                      button_color_blue;
    logic                      button_color_yellow;
    logic                      start;
    logic                      enable;
    logic                      color_valid;
    logic [COLOR_CODEFY_W-1:0] color_code;
    logic                      multi_press_err;
    logic                      start_pulse;

    modport master (
        output button_color_green,
        output button_color_red,
        output button_color_blue,
        output button_color_yellow,
        output start,
        output enable,
        input  color_valid,
        input  color_code,
        input  multi_press_err,
        input  start_pulse
    );

    modport slave (
        input  button_color_green,
        input  button_color_red,
        input  button_color_blue,
        input  button_color_yellow,
        input  start,
        input  enable,
        output color_valid,
        output color_code,
        output multi_press_err,
        output start_pulse
    );

endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a counter debouncer for one raw button.
// rise_o pulses for one cycle alongside the first cycle of a debounced high.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_d;
    logic            rise_q;
    logic            rise_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Counter only runs while the synchronized level disagrees with the accepted one.
    always_comb begin
        stable_d = stable_q;
        rise_d   = 1'b0;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntMax) begin
                stable_d = ~stable_q;
                rise_d   = ~stable_q;
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;

endmodule

// File: rtl/color_input_conditioner.sv
// Turns four debounced colour buttons into single accepted press pulses with a
// colour code, rejecting overlapping presses, plus a debounced start pulse.
module color_input_conditioner
    import genius_pkg::*;
#(
    parameter int unsigned COLOR_CODEFY_W  = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 2
) (
    input logic                      clk,
    input logic                      rst_n,
    color_input_conditioner_if.slave bus_io
);

    localparam logic [NumColors-1:0] RiseOne = NumColors'(1);

    logic [NumColors-1:0]      raw_colors;
    logic [NumColors-1:0]      color_stable;
    logic [NumColors-1:0]      color_rise;
    logic                      start_rise;
    logic                      unused_start_stable;
    logic                      any_press;
    logic                      single_press;
    logic                      multi_press;

    cond_state_e               state_q;
    cond_state_e               state_d;
    logic                      color_valid_q;
    logic                      color_valid_d;
    logic [COLOR_CODEFY_W-1:0] color_code_q;
    logic [COLOR_CODEFY_W-1:0] color_code_d;
    logic                      multi_press_err_q;
    logic                      multi_press_err_d;
    logic                      start_pulse_q;

    // Bit position equals the colour code.
    assign raw_colors = {bus_io.button_color_yellow, bus_io.button_color_blue,
                         bus_io.button_color_red, bus_io.button_color_green};

    for (genvar i = 0; i < NumColors; i++) begin : g_color_db
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (raw_colors[i]),
            .stable_o(color_stable[i]),
            .rise_o  (color_rise[i])
        );
    end

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (bus_io.start),
        .stable_o(unused_start_stable),
        .rise_o  (start_rise)
    );

    // x & (x - 1) clears the lowest set bit, so it is zero only for a single press.
    assign any_press    = |color_rise;
    assign single_press = any_press && ((color_rise & (color_rise - RiseOne)) == '0);
    assign multi_press  = any_press && !single_press;

    always_comb begin
        state_d           = state_q;
        color_valid_d     = 1'b0;
        color_code_d      = color_code_q;
        multi_press_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (single_press) begin
                    // A press seen while disabled still locks out until release.
                    if (bus_io.enable) begin
                        color_valid_d = 1'b1;
                        color_code_d  = COLOR_CODEFY_W'(onehot_to_color(color_rise));
                    end
                    state_d = StHeld;
                end else if (multi_press) begin
                    multi_press_err_d = 1'b1;
                    state_d           = StHeld;
                end
            end
            StHeld: begin
                if (any_press) begin
                    multi_press_err_d = 1'b1;
                end else if (color_stable == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            color_valid_q     <= 1'b0;
            color_code_q      <= '0;
            multi_press_err_q <= 1'b0;
            start_pulse_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            color_valid_q     <= color_valid_d;
            color_code_q      <= color_code_d;
            multi_press_err_q <= multi_press_err_d;
            start_pulse_q     <= start_rise;
        end
    end

    assign bus_io.color_valid     = color_valid_q;
    assign bus_io.color_code      = color_code_q;
    assign bus_io.multi_press_err = multi_press_err_q;
    assign bus_io.start_pulse     = start_pulse_q;

endmodule
